// File: rtl/mac_stream_buffer_bank.sv
// Per-channel stream FIFOs between TCDM sources and the MAC engine, with beat
// counters bounded by a per-job length and a small IDLE/RUN/DONE job FSM.
module mac_stream_buffer_bank #(
    parameter int NCH = 4,
    parameter int DW  = 32,
    parameter int FD  = 2,
    parameter int CW  = 16,
    localparam int LW = $clog2(FD + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [NCH*CW-1:0] len_i,
    input  logic [NCH-1:0]    push_valid_i,
    input  logic [NCH*DW-1:0] push_data_i,
    output logic [NCH-1:0]    push_ready_o,
    output logic [NCH-1:0]    pop_valid_o,
    output logic [NCH*DW-1:0] pop_data_o,
    input  logic [NCH-1:0]    pop_ready_i,
    output logic [NCH*LW-1:0] level_o,
    output logic [NCH-1:0]    empty_o,
    output logic [NCH-1:0]    full_o,
    output logic [NCH-1:0]    done_o,
    output logic              all_done_o
);

    localparam int PW = $clog2(FD);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FD - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] mem_q      [NCH][FD];
    logic [DW-1:0] mem_d      [NCH][FD];
    logic [PW-1:0] wptr_q     [NCH];
    logic [PW-1:0] wptr_d     [NCH];
    logic [PW-1:0] rptr_q     [NCH];
    logic [PW-1:0] rptr_d     [NCH];
    logic [LW-1:0] level_q    [NCH];
    logic [LW-1:0] level_d    [NCH];
    logic [CW-1:0] push_cnt_q [NCH];
    logic [CW-1:0] push_cnt_d [NCH];
    logic [CW-1:0] pop_cnt_q  [NCH];
    logic [CW-1:0] pop_cnt_d  [NCH];
    logic [CW-1:0] len_q      [NCH];
    logic [CW-1:0] len_d      [NCH];

    logic           run_s;
    logic [NCH-1:0] push_ready_s;
    logic [NCH-1:0] pop_valid_s;
    logic [NCH-1:0] push_fire_s;
    logic [NCH-1:0] pop_fire_s;
    logic [NCH-1:0] cnt_done_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign run_s = (state_q == ST_RUN);

    // Handshake terms depend only on registered state and enable, never on the partner signal.
    always_comb begin
        push_ready_s = '0;
        pop_valid_s  = '0;
        cnt_done_s   = '0;
        for (int c = 0; c < NCH; c++) begin
            push_ready_s[c] = enable_i & run_s & (level_q[c] != LVL_FULL)
                              & (push_cnt_q[c] < len_q[c]);
            pop_valid_s[c]  = enable_i & run_s & (level_q[c] != '0)
                              & (pop_cnt_q[c] < len_q[c]);
            cnt_done_s[c]   = (pop_cnt_q[c] == len_q[c]);
        end
    end

    assign push_fire_s = push_valid_i & push_ready_s;
    assign pop_fire_s  = pop_ready_i & pop_valid_s;

    // Next-state: clear beats start; start is ignored while a job is running.
    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        push_cnt_d = push_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        len_d      = len_q;
        if (clear_i) begin
            state_d = ST_IDLE;
            for (int c = 0; c < NCH; c++) begin
                for (int e = 0; e < FD; e++) begin
                    mem_d[c][e] = '0;
                end
                wptr_d[c]     = '0;
                rptr_d[c]     = '0;
                level_d[c]    = '0;
                push_cnt_d[c] = '0;
                pop_cnt_d[c]  = '0;
            end
        end else if (start_i && !run_s) begin
            state_d = ST_RUN;
            for (int c = 0; c < NCH; c++) begin
                len_d[c]      = len_i[c*CW +: CW];
                push_cnt_d[c] = '0;
                pop_cnt_d[c]  = '0;
            end
        end else if (enable_i && run_s) begin
            for (int c = 0; c < NCH; c++) begin
                if (push_fire_s[c]) begin
                    mem_d[c][wptr_q[c]] = push_data_i[c*DW +: DW];
                    wptr_d[c]           = next_ptr(wptr_q[c]);
                    push_cnt_d[c]       = push_cnt_q[c] + CW'(1);
                end else begin
                    wptr_d[c]     = wptr_q[c];
                    push_cnt_d[c] = push_cnt_q[c];
                end
                if (pop_fire_s[c]) begin
                    rptr_d[c]    = next_ptr(rptr_q[c]);
                    pop_cnt_d[c] = pop_cnt_q[c] + CW'(1);
                end else begin
                    rptr_d[c]    = rptr_q[c];
                    pop_cnt_d[c] = pop_cnt_q[c];
                end
                case ({push_fire_s[c], pop_fire_s[c]})
                    2'b10:   level_d[c] = level_q[c] + LW'(1);
                    2'b01:   level_d[c] = level_q[c] - LW'(1);
                    default: level_d[c] = level_q[c];
                endcase
            end
            if (&cnt_done_s) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State registers, storage included so the head reads zero after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            for (int c = 0; c < NCH; c++) begin
                for (int e = 0; e < FD; e++) begin
                    mem_q[c][e] <= '0;
                end
                wptr_q[c]     <= '0;
                rptr_q[c]     <= '0;
                level_q[c]    <= '0;
                push_cnt_q[c] <= '0;
                pop_cnt_q[c]  <= '0;
                len_q[c]      <= '0;
            end
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            len_q      <= len_d;
        end
    end

    // Status outputs are pure functions of registered state.
    always_comb begin
        pop_data_o = '0;
        level_o    = '0;
        empty_o    = '0;
        full_o     = '0;
        done_o     = '0;
        for (int c = 0; c < NCH; c++) begin
            pop_data_o[c*DW +: DW] = mem_q[c][rptr_q[c]];
            level_o[c*LW +: LW]    = level_q[c];
            empty_o[c]             = (level_q[c] == '0);
            full_o[c]              = (level_q[c] == LVL_FULL);
            done_o[c]              = (state_q != ST_IDLE) & cnt_done_s[c];
        end
    end

    assign push_ready_o = push_ready_s;
    assign pop_valid_o  = pop_valid_s;
    assign all_done_o   = (state_q == ST_DONE);

endmodule
